// File: rtl/hex_word_assembler.sv
// Assembles ASCII hex digits into a right-aligned word. CR or LF ends a line; a bad
// character or too many digits poisons the line until its terminator arrives.
module hex_word_assembler #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [4*DIGITS-1:0]   word,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [3:0]            digit_count,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD, ERR} state_t;

    localparam logic [3:0] MAX_CNT = 4'(DIGITS);

    state_t                state_q;
    logic [4*DIGITS-1:0]   acc_q;
    logic [4*DIGITS-1:0]   word_q;
    logic [3:0]            cnt_q;
    logic                  word_valid_q;
    logic                  err_q;

    logic                  isHex;
    logic                  isTerm;
    logic [3:0]            nibble;

    // Letters map through their low nibble: 'A'/'a' have low nibble 1, so add 9 to get 0xA.
    always_comb begin
        isHex  = 1'b0;
        nibble = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            isHex  = 1'b1;
            nibble = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            isHex  = 1'b1;
            nibble = rx_data[3:0] + 4'd9;
        end
    end

    assign isTerm = (rx_data == 8'h0D) || (rx_data == 8'h0A);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            word_q       <= '0;
            cnt_q        <= 4'd0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (rx_valid) begin
                        if (isTerm) begin
                            // A terminator on an empty line is a CR/LF pair or blank line.
                            if (state_q == ACCUM) begin
                                word_q       <= acc_q;
                                word_valid_q <= 1'b1;
                                state_q      <= HOLD;
                            end
                        end else if (isHex && cnt_q != MAX_CNT) begin
                            acc_q   <= {acc_q[4*DIGITS-5:0], nibble};
                            cnt_q   <= cnt_q + 4'd1;
                            state_q <= ACCUM;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                end
                ERR: begin
                    if (rx_valid && isTerm) begin
                        acc_q   <= '0;
                        cnt_q   <= 4'd0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        acc_q        <= '0;
                        cnt_q        <= 4'd0;
                        word_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_ready    = (state_q != HOLD);
    assign word        = word_q;
    assign word_valid  = word_valid_q;
    assign digit_count = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_hex_word_assembler.sv
// Directed scenarios plus random character streams for hex_word_assembler, checked against
// a line-buffer model that re-evaluates the whole current line from the character rules.
module tb_hex_word_assembler;

    localparam int DIGITS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  digit_count;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Model: characters of the current line, whether a word is pending, and the last word.
    byte unsigned line[$];
    bit           holding;
    logic [31:0]  lastWord;

    hex_word_assembler #(.DIGITS(DIGITS)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .word(word),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .digit_count(digit_count),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic int hexVal(byte unsigned c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 65 + 10;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 97 + 10;
        return -1;
    endfunction

    function automatic bit isTermChar(byte unsigned c);
        return (c == 8'h0D) || (c == 8'h0A);
    endfunction

    // Digits count until the line goes bad; after that the line is only waiting for its end.
    function automatic void evalLine(output bit bad, output int cnt, output logic [31:0] val);
        bad = 1'b0;
        cnt = 0;
        val = 32'h0;
        foreach (line[i]) begin
            if (!bad) begin
                if (hexVal(line[i]) < 0 || cnt == DIGITS) bad = 1'b1;
                else begin
                    val = val * 16 + 32'(hexVal(line[i]));
                    cnt++;
                end
            end
        end
    endfunction

    function automatic void modelReset();
        line.delete();
        holding  = 1'b0;
        lastWord = 32'h0;
    endfunction

    function automatic void modelClock(bit v, byte unsigned d, bit r);
        bit          bad;
        int          cnt;
        logic [31:0] val;
        if (holding) begin
            if (r) begin
                holding = 1'b0;
                line.delete();
            end
        end else if (v) begin
            if (isTermChar(d)) begin
                if (line.size() != 0) begin
                    evalLine(bad, cnt, val);
                    if (bad) line.delete();
                    else begin
                        holding  = 1'b1;
                        lastWord = val;
                    end
                end
            end else begin
                line.push_back(d);
            end
        end
    endfunction

    task automatic checkOutput(input string tag);
        bit          bad;
        int          cnt;
        logic [31:0] val;
        evalLine(bad, cnt, val);
        checks++;
        assert (word === lastWord) else begin
            failures++;
            $error("[TB] FAIL %s word: got %h expected %h", tag, word, lastWord);
        end
        checks++;
        assert (word_valid === holding) else begin
            failures++;
            $error("[TB] FAIL %s word_valid: got %b expected %b", tag, word_valid, holding);
        end
        checks++;
        assert (rx_ready === !holding) else begin
            failures++;
            $error("[TB] FAIL %s rx_ready: got %b expected %b", tag, rx_ready, !holding);
        end
        checks++;
        assert (err === bad) else begin
            failures++;
            $error("[TB] FAIL %s err: got %b expected %b", tag, err, bad);
        end
        checks++;
        assert (digit_count === 4'(cnt)) else begin
            failures++;
            $error("[TB] FAIL %s digit_count: got %0d expected %0d", tag, digit_count, cnt);
        end
    endtask

    task automatic applyStimulus(input bit v, input byte unsigned d, input bit r, input string tag);
        rx_valid   = v;
        rx_data    = d;
        word_ready = r;
        @(posedge clk);
        modelClock(v, d, r);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendString(input string s, input bit r, input string tag);
        for (int i = 0; i < s.len(); i++) applyStimulus(1'b1, s[i], r, tag);
    endtask

    // Reset pulse placed between clock edges; outputs must clear before any edge arrives.
    task automatic asyncReset(input string tag);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        string pool;
        pool       = "0123456789abcdefABCDEF";
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        word_ready = 1'b0;
        modelReset();
        #12;
        checkOutput("reset");
        rst = 1'b0;

        // Full-width word with downstream always ready: one-cycle word_valid pulse.
        sendString("DEADbeef", 1'b1, "s1_digits");
        applyStimulus(1'b1, 8'h0D, 1'b1, "s1_term");
        applyStimulus(1'b0, 8'h00, 1'b1, "s1_hold");
        applyStimulus(1'b0, 8'h00, 1'b1, "s1_after");

        // Backpressure: HOLD persists with rx_valid held high until word_ready rises.
        sendString("7", 1'b0, "s2_digit");
        applyStimulus(1'b1, 8'h0A, 1'b0, "s2_term");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h41, 1'b0, "s2_stall");
        applyStimulus(1'b1, 8'h41, 1'b1, "s2_handoff");
        applyStimulus(1'b1, 8'h41, 1'b0, "s2_next");
        applyStimulus(1'b1, 8'h0D, 1'b1, "s2_term2");
        applyStimulus(1'b0, 8'h00, 1'b1, "s2_drain");

        // Overflow on the ninth digit.
        sendString("123456789", 1'b1, "s3_digits");
        applyStimulus(1'b1, 8'h0D, 1'b1, "s3_term");

        // Invalid character, then a short recovery word.
        sendString("12G4", 1'b1, "s4_bad");
        applyStimulus(1'b1, 8'h0D, 1'b1, "s4_term");
        sendString("A", 1'b1, "s4_digit");
        applyStimulus(1'b1, 8'h0D, 1'b1, "s4_term2");
        applyStimulus(1'b0, 8'h00, 1'b1, "s4_drain");

        // Bare terminators produce nothing.
        applyStimulus(1'b1, 8'h0D, 1'b1, "s5_cr");
        applyStimulus(1'b1, 8'h0A, 1'b1, "s5_lf");
        applyStimulus(1'b1, 8'h0D, 1'b1, "s5_cr2");

        // Asynchronous reset mid-word, then in HOLD.
        sendString("AB", 1'b1, "s6_digits");
        asyncReset("s6_rst");
        sendString("C", 1'b1, "s6_digit");
        applyStimulus(1'b1, 8'h0D, 1'b0, "s6_term");
        asyncReset("s6_rst_hold");
        applyStimulus(1'b0, 8'h00, 1'b1, "s6_after");

        // Random streams of digits, terminators and junk with random backpressure.
        for (int n = 0; n < 600; n++) begin
            int          pick;
            byte unsigned c;
            pick = int'($urandom_range(99));
            if (pick < 60)      c = pool[int'($urandom_range(pool.len() - 1))];
            else if (pick < 80) c = ($urandom_range(1) != 0) ? 8'h0D : 8'h0A;
            else                c = 8'($urandom);
            applyStimulus($urandom_range(9) < 8, c, $urandom_range(1) != 0, "rand");
            if ($urandom_range(99) == 0) asyncReset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
